// File: rtl/dec_op_case_pkg.sv
// -----------------------------------------------------------------------------
// dec_op_case_pkg
//   Shared constants for the decoded-operation block:
//     DEFAULT_WIDTH  default operand width of dec_op_case
//     OP_ADD/OP_SUB/OP_MUL/OP_LOGIC  values of DEC selecting each result
//     NUM_OPS        number of result outputs (one per DEC code)
//   Helper:
//     op_name()      short text name of an operation code (debug/bench use)
// -----------------------------------------------------------------------------
package dec_op_case_pkg;

  localparam int DEFAULT_WIDTH = 4;
  localparam int NUM_OPS       = 4;

  localparam logic [1:0] OP_ADD   = 2'b00;
  localparam logic [1:0] OP_SUB   = 2'b01;
  localparam logic [1:0] OP_MUL   = 2'b10;
  localparam logic [1:0] OP_LOGIC = 2'b11;

  function automatic string op_name(input logic [1:0] op);
    string s;
    case (op)
      OP_ADD:   s = "add";
      OP_SUB:   s = "sub";
      OP_MUL:   s = "mul";
      default:  s = "logic";
    endcase
    return s;
  endfunction

endpackage : dec_op_case_pkg

// File: rtl/dec_op_case_dec2to4.sv
// -----------------------------------------------------------------------------
// dec2to4
//   Enabled 2-to-4 decoder producing a one-hot select; all zero when the
//   enable is low.
//   Ports:
//     dec     [1:0]  operation code
//     enable         decode enable, active-high
//     sel     [3:0]  one-hot select, sel[i] = enable && (dec == i)
// -----------------------------------------------------------------------------
module dec2to4
  import dec_op_case_pkg::*;
(
  input  logic [1:0]         dec,
  input  logic               enable,
  output logic [NUM_OPS-1:0] sel
);

  for (genvar gi = 0; gi < NUM_OPS; gi++) begin : g_sel
    assign sel[gi] = enable && (dec == 2'(gi));
  end

endmodule : dec2to4

// File: rtl/dec_op_case.sv
// -----------------------------------------------------------------------------
// dec_op_case
//   Registered decoded-operation unit. Each cycle the operation chosen by DEC
//   is computed combinationally from A and B; on the rising CLK edge the
//   selected output loads its result and every other output loads 0, so at
//   most one output is non-zero at any time. With ENABLE low all outputs
//   load 0.
//
//   Optional feature macro: DEC_OP_CASE_MUL_EN
//     defined   -> op2 carries the full unsigned product A*B
//     undefined -> no multiplier is built and op2 is constant 0
//
//   Ports:
//     CLK           clock, rising edge
//     RST           asynchronous active-high reset, clears op0..op3
//     A, B  [W-1:0] unsigned operands
//     DEC   [1:0]   operation select (00 add, 01 sub, 10 mul, 11 logic)
//     ENABLE        operation enable, active-high
//     op0  [2W-1:0] A+B, zero-extended (carry kept)
//     op1  [2W-1:0] A-B, two's complement, sign-extended
//     op2  [2W-1:0] A*B, unsigned full product (0 without the macro)
//     op3  [2W-1:0] {A|B, A&B}
// -----------------------------------------------------------------------------
module dec_op_case
  import dec_op_case_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  input  logic [1:0]           DEC,
  input  logic                 ENABLE,
  output logic [2*WIDTH-1:0]   op0,
  output logic [2*WIDTH-1:0]   op1,
  output logic [2*WIDTH-1:0]   op2,
  output logic [2*WIDTH-1:0]   op3
);

  localparam int RW = 2 * WIDTH;

  logic [NUM_OPS-1:0]         sel;
  logic [WIDTH:0]             sum_w;
  logic [WIDTH:0]             diff_w;
  logic [NUM_OPS-1:0][RW-1:0] result;

  dec2to4 u_dec (
    .dec    (DEC),
    .enable (ENABLE),
    .sel    (sel)
  );

  // All four results are formed in parallel; the decoder only decides which
  // one gets captured, so a simultaneous DEC and operand change is simply a
  // new operation on the next edge.
  always_comb begin
    // One extra bit keeps the carry of the sum and the sign of the
    // difference (|A-B| < 2**WIDTH, so WIDTH+1 signed bits always suffice).
    sum_w  = {1'b0, A} + {1'b0, B};
    diff_w = {1'b0, A} - {1'b0, B};

    result           = '0;
    result[OP_ADD]   = RW'(sum_w);
    result[OP_SUB]   = RW'($signed(diff_w));
`ifdef DEC_OP_CASE_MUL_EN
    result[OP_MUL]   = RW'(A) * RW'(B);
`endif
    result[OP_LOGIC] = {A | B, A & B};
  end

  // One output register per operation. Unselected registers load 0 rather
  // than holding, which keeps the outputs mutually exclusive.
  for (genvar gi = 0; gi < NUM_OPS; gi++) begin : g_reg
    logic [RW-1:0] q_reg;

    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        q_reg <= '0;
      end else begin
        q_reg <= sel[gi] ? result[gi] : '0;
      end
    end
  end

  assign op0 = g_reg[OP_ADD].q_reg;
  assign op1 = g_reg[OP_SUB].q_reg;
  assign op2 = g_reg[OP_MUL].q_reg;
  assign op3 = g_reg[OP_LOGIC].q_reg;

endmodule : dec_op_case

// File: tb/tb_dec_op_case.sv
// -----------------------------------------------------------------------------
// tb_dec_op_case
//   Directed, table-driven bench for dec_op_case (WIDTH = 4). Expected op2
//   values follow DEC_OP_CASE_MUL_EN so the bench fits either build.
// -----------------------------------------------------------------------------
module tb_dec_op_case;
  import dec_op_case_pkg::*;

  localparam int W = 4;

`ifdef DEC_OP_CASE_MUL_EN
  localparam bit MUL_ON = 1'b1;
`else
  localparam bit MUL_ON = 1'b0;
`endif

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic [1:0]   DEC = 2'b00;
  logic         ENABLE = 1'b0;
  logic [7:0]   op0, op1, op2, op3;

  int n_cmp = 0;
  int n_bad = 0;

  dec_op_case #(.WIDTH(W)) dut (
    .CLK    (CLK),
    .RST    (RST),
    .A      (A),
    .B      (B),
    .DEC    (DEC),
    .ENABLE (ENABLE),
    .op0    (op0),
    .op1    (op1),
    .op2    (op2),
    .op3    (op3)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] dec;
    logic       en;
    logic [7:0] e0;
    logic [7:0] e1;
    logic [7:0] e2;
    logic [7:0] e3;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%02h, want 0x%02h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                         input logic [7:0] e2, input logic [7:0] e3);
    chk({tag, ".op0"}, op0, e0);
    chk({tag, ".op1"}, op1, e1);
    chk({tag, ".op2"}, op2, e2);
    chk({tag, ".op3"}, op3, e3);
  endtask

  task automatic add_vec(input logic [3:0] a, input logic [3:0] b, input logic [1:0] dec,
                         input logic en, input logic [7:0] e0, input logic [7:0] e1,
                         input logic [7:0] e2, input logic [7:0] e3);
    vec_t v;
    v.a = a; v.b = b; v.dec = dec; v.en = en;
    v.e0 = e0; v.e1 = e1; v.e2 = e2; v.e3 = e3;
    vecs.push_back(v);
  endtask

  // Watchdog: the bench is bounded by its own clock count, this only guards
  // against a broken simulator setup.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "timeout");
  end

  initial begin
    // ---- vector table: enabled operations, then the same stimulus disabled
    add_vec(4'h0, 4'h0, OP_ADD,   1'b1, 8'h00, 8'h00, 8'h00, 8'h00);
    add_vec(4'h1, 4'h1, OP_ADD,   1'b1, 8'h02, 8'h00, 8'h00, 8'h00);
    add_vec(4'hF, 4'hF, OP_ADD,   1'b1, 8'h1E, 8'h00, 8'h00, 8'h00);
    add_vec(4'h2, 4'h2, OP_SUB,   1'b1, 8'h00, 8'h00, 8'h00, 8'h00);
    add_vec(4'h1, 4'h2, OP_SUB,   1'b1, 8'h00, 8'hFF, 8'h00, 8'h00);
    add_vec(4'h0, 4'hF, OP_SUB,   1'b1, 8'h00, 8'hF1, 8'h00, 8'h00);
    add_vec(4'hF, 4'h0, OP_SUB,   1'b1, 8'h00, 8'h0F, 8'h00, 8'h00);
    add_vec(4'h3, 4'h3, OP_MUL,   1'b1, 8'h00, 8'h00, MUL_ON ? 8'h09 : 8'h00, 8'h00);
    add_vec(4'h4, 4'h4, OP_MUL,   1'b1, 8'h00, 8'h00, MUL_ON ? 8'h10 : 8'h00, 8'h00);
    add_vec(4'hF, 4'hF, OP_MUL,   1'b1, 8'h00, 8'h00, MUL_ON ? 8'hE1 : 8'h00, 8'h00);
    add_vec(4'h7, 4'h7, OP_LOGIC, 1'b1, 8'h00, 8'h00, 8'h00, 8'h77);
    add_vec(4'hC, 4'h5, OP_LOGIC, 1'b1, 8'h00, 8'h00, 8'h00, 8'hD4);
    add_vec(4'h1, 4'h1, OP_ADD,   1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
    add_vec(4'h1, 4'h2, OP_SUB,   1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
    add_vec(4'h3, 4'h3, OP_MUL,   1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
    add_vec(4'hC, 4'h5, OP_LOGIC, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
    // back-to-back change of DEC and operands after a disabled cycle
    add_vec(4'h9, 4'h8, OP_ADD,   1'b1, 8'h11, 8'h00, 8'h00, 8'h00);
    add_vec(4'h3, 4'h6, OP_LOGIC, 1'b1, 8'h00, 8'h00, 8'h00, 8'h72);

    // ---- reset state: asynchronous, visible before any clock edge
    #2;
    chk_all("reset_t0", 8'h00, 8'h00, 8'h00, 8'h00);
    ENABLE = 1'b1; DEC = OP_ADD; A = 4'h5; B = 4'h6;
    repeat (2) @(posedge CLK);
    #1;
    chk_all("reset_held", 8'h00, 8'h00, 8'h00, 8'h00);
    @(negedge CLK);
    RST = 1'b0;
    @(posedge CLK); #1;
    chk_all("first_edge", 8'h0B, 8'h00, 8'h00, 8'h00);
    $display("seq first_edge after reset: op0=0x%02h", op0);

    // ---- table loop
    foreach (vecs[i]) begin
      @(negedge CLK);
      A = vecs[i].a; B = vecs[i].b; DEC = vecs[i].dec; ENABLE = vecs[i].en;
      @(posedge CLK); #1;
      chk_all($sformatf("vec%0d", i), vecs[i].e0, vecs[i].e1, vecs[i].e2, vecs[i].e3);
      $display("vec %0d %s a=%h b=%h en=%b -> op0=%02h op1=%02h op2=%02h op3=%02h",
               i, op_name(vecs[i].dec), vecs[i].a, vecs[i].b, vecs[i].en, op0, op1, op2, op3);
    end

    // ---- mid-cycle reset clears a loaded result immediately
    @(negedge CLK);
    A = 4'h7; B = 4'h7; DEC = OP_LOGIC; ENABLE = 1'b1;
    @(posedge CLK); #1;
    chk("pre_reset.op3", op3, 8'h77);
    @(negedge CLK);
    RST = 1'b1;
    #1;
    chk_all("async_reset", 8'h00, 8'h00, 8'h00, 8'h00);
    @(posedge CLK); #1;
    chk_all("reset_over_edge", 8'h00, 8'h00, 8'h00, 8'h00);
    // release with a new operation queued: the first edge loads it normally
    @(negedge CLK);
    A = 4'h1; B = 4'h2; DEC = OP_SUB;
    RST = 1'b0;
    #1;
    chk_all("released_pre_edge", 8'h00, 8'h00, 8'h00, 8'h00);
    @(posedge CLK); #1;
    chk_all("release_load", 8'h00, 8'hFF, 8'h00, 8'h00);
    $display("seq reset mid-operation, release: op1=0x%02h", op1);

    // ---- reset during a pending operation: no stale value after release
    @(negedge CLK);
    A = 4'hA; B = 4'h3; DEC = OP_ADD;
    #2;
    RST = 1'b1;
    #1;
    chk_all("pending_reset", 8'h00, 8'h00, 8'h00, 8'h00);
    ENABLE = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    @(posedge CLK); #1;
    chk_all("no_stale", 8'h00, 8'h00, 8'h00, 8'h00);
    $display("seq pending operation discarded by reset: op0=0x%02h", op0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_dec_op_case
